// File: rtl/game_round_ctrl_pkg.sv
// Shared whack-a-mole definitions: controller state codes and round defaults.
// Imported by the round, score and mole controllers.
package wam_defs;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } wam_state_e;

    localparam int GAME_SECONDS_DEF = 60;
    localparam int CLEAR_CYCLES_DEF = 4;

endpackage

// File: rtl/game_round_ctrl_if.sv
// Round controller signal bundle: player inputs, counter link, display.
// master drives the raw inputs, slave is the controller.
interface game_round_ctrl_if;

    logic       start_btn;
    logic       pause_sw;
    logic [5:0] elapsed_time;
    logic       start_game;
    logic       timer_clear_n;
    logic       game_active;
    logic       game_over;
    logic       sec_tick;
    logic [3:0] time_tens;
    logic [3:0] time_ones;

    modport master (
        output start_btn, pause_sw, elapsed_time,
        input  start_game, timer_clear_n, game_active,
        input  game_over, sec_tick, time_tens, time_ones
    );

    modport slave (
        input  start_btn, pause_sw, elapsed_time,
        output start_game, timer_clear_n, game_active,
        output game_over, sec_tick, time_tens, time_ones
    );

endinterface

// File: rtl/game_round_ctrl_bcd.sv
// 6-bit binary to two BCD digits using range compares and
// constant subtracts only.
module bin6_to_bcd2 (
    input  logic [5:0] i_bin,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones
);

    always_comb begin
        o_tens = 4'd0;
        o_ones = i_bin[3:0];
        unique case (1'b1)
            (i_bin >= 6'd60): begin
                o_tens = 4'd6;
                o_ones = 4'(i_bin - 6'd60);
            end
            (i_bin >= 6'd50 && i_bin < 6'd60): begin
                o_tens = 4'd5;
                o_ones = 4'(i_bin - 6'd50);
            end
            (i_bin >= 6'd40 && i_bin < 6'd50): begin
                o_tens = 4'd4;
                o_ones = 4'(i_bin - 6'd40);
            end
            (i_bin >= 6'd30 && i_bin < 6'd40): begin
                o_tens = 4'd3;
                o_ones = 4'(i_bin - 6'd30);
            end
            (i_bin >= 6'd20 && i_bin < 6'd30): begin
                o_tens = 4'd2;
                o_ones = 4'(i_bin - 6'd20);
            end
            (i_bin >= 6'd10 && i_bin < 6'd20): begin
                o_tens = 4'd1;
                o_ones = 4'(i_bin - 6'd10);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller: syncs player inputs and the ripple seconds counter,
// runs the round FSM and drives the remaining-time BCD display.
module game_round_ctrl
    import wam_defs::*;
#(
    parameter int GAME_SECONDS = GAME_SECONDS_DEF,
    parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    game_round_ctrl_if.slave bus
);

    localparam logic [5:0] GS6      = 6'(GAME_SECONDS);
    localparam logic [7:0] CLR_LAST = 8'(CLEAR_CYCLES - 1);
    localparam logic [3:0] RST_TENS = 4'(GAME_SECONDS / 10);
    localparam logic [3:0] RST_ONES = 4'(GAME_SECONDS % 10);

    logic       r_start_s1, r_start_s2, r_start_d;
    logic       r_pause_s1, r_pause_s2;
    logic [5:0] r_el_s1, r_el_s2, r_el_prev;
    logic [5:0] r_elapsed_q;
    logic [7:0] r_clr_cnt;
    wam_state_e r_state;
    wam_state_e w_next;
    logic       r_start_game, r_clear_n, r_active, r_over, r_tick;
    logic [3:0] r_tens, r_ones;
    logic       w_start_req, w_done, w_accept;
    logic [5:0] w_rem, w_show;
    logic [3:0] w_tens, w_ones;

    assign w_start_req = r_start_s2 & ~r_start_d;
    assign w_done      = (r_elapsed_q >= GS6);
    assign w_rem       = w_done ? 6'd0 : GS6 - r_elapsed_q;
    // Ripple codes settle well within a clk; two equal samples mean stable.
    assign w_accept    = (r_el_s2 == r_el_prev)
                      && (r_el_s2 != r_elapsed_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_s1  <= 1'b0;
            r_start_s2  <= 1'b0;
            r_start_d   <= 1'b0;
            r_pause_s1  <= 1'b0;
            r_pause_s2  <= 1'b0;
            r_el_s1     <= 6'd0;
            r_el_s2     <= 6'd0;
            r_el_prev   <= 6'd0;
            r_elapsed_q <= 6'd0;
            r_tick      <= 1'b0;
        end else begin
            r_start_s1 <= bus.start_btn;
            r_start_s2 <= r_start_s1;
            r_start_d  <= r_start_s2;
            r_pause_s1 <= bus.pause_sw;
            r_pause_s2 <= r_pause_s1;
            r_el_s1    <= bus.elapsed_time;
            r_el_s2    <= r_el_s1;
            r_el_prev  <= r_el_s2;
            if (r_state == ST_CLEAR)
                r_elapsed_q <= 6'd0;
            else if (w_accept)
                r_elapsed_q <= r_el_s2;
            r_tick <= w_accept && (r_state != ST_CLEAR);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:
                if (w_start_req) w_next = ST_CLEAR;
            ST_CLEAR:
                if (r_clr_cnt == CLR_LAST) w_next = ST_RUN;
            ST_RUN:
                if (w_done) w_next = ST_OVER;
                else if (r_pause_s2) w_next = ST_PAUSE;
            ST_PAUSE:
                if (w_start_req) w_next = ST_CLEAR;
                else if (!r_pause_s2) w_next = ST_RUN;
            ST_OVER:
                if (w_start_req) w_next = ST_CLEAR;
            default:
                w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        unique case (r_state)
            ST_OVER:  w_show = 6'd0;
            ST_CLEAR: w_show = GS6;
            default:  w_show = w_rem;
        endcase
    end

    bin6_to_bcd2 u_bcd (
        .i_bin  (w_show),
        .o_tens (w_tens),
        .o_ones (w_ones)
    );

    // Outputs are decoded from the next state so they align with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_clr_cnt    <= 8'd0;
            r_start_game <= 1'b0;
            r_clear_n    <= 1'b0;
            r_active     <= 1'b0;
            r_over       <= 1'b0;
            r_tens       <= RST_TENS;
            r_ones       <= RST_ONES;
        end else begin
            r_state      <= w_next;
            r_clr_cnt    <= (r_state == ST_CLEAR)
                          ? r_clr_cnt + 8'd1 : 8'd0;
            r_start_game <= (w_next == ST_RUN);
            r_clear_n    <= (w_next == ST_RUN)
                         || (w_next == ST_PAUSE)
                         || (w_next == ST_OVER);
            r_active     <= (w_next == ST_RUN);
            r_over       <= (w_next == ST_OVER);
            r_tens       <= w_tens;
            r_ones       <= w_ones;
        end
    end

    assign bus.start_game    = r_start_game;
    assign bus.timer_clear_n = r_clear_n;
    assign bus.game_active   = r_active;
    assign bus.game_over     = r_over;
    assign bus.sec_tick      = r_tick;
    assign bus.time_tens     = r_tens;
    assign bus.time_ones     = r_ones;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: vector table, hand sequences and a
// randomized seconds walk checked against remaining-time arithmetic.
module tb_game_round_ctrl;

    localparam int GS = 60;
    localparam int CC = 4;

    typedef struct {
        int sec;
        int ng;
        int tens;
        int ones;
        int over;
    } vec_t;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   ticks    = 0;
    int   falls    = 0;
    logic prev_clr = 1'b0;
    int   last_drv = 0;

    game_round_ctrl_if bus ();

    game_round_ctrl #(
        .GAME_SECONDS (GS),
        .CLEAR_CYCLES (CC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.sec_tick) ticks++;
        if (prev_clr && !bus.timer_clear_n) falls++;
        prev_clr = bus.timer_clear_n;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle glitch codes, then the settled value.
    task automatic drive_sec(input int v, input int ng);
        for (int g = 0; g < ng; g++) begin
            int gv;
            gv = int'($urandom_range(0, 63));
            while (gv == last_drv) gv = int'($urandom_range(0, 63));
            @(negedge clk);
            bus.elapsed_time = 6'(gv);
            last_drv = gv;
        end
        @(negedge clk);
        bus.elapsed_time = 6'(v);
        last_drv = v;
    endtask

    task automatic apply(input string tag, input int v, input int ng,
                         input int et, input int eo, input int eov,
                         input int etk);
        int t0;
        t0 = ticks;
        drive_sec(v, ng);
        step(5);
        chk({tag, " tens"}, int'(bus.time_tens), et);
        chk({tag, " ones"}, int'(bus.time_ones), eo);
        chk({tag, " over"}, int'(bus.game_over), eov);
        chk({tag, " start_game"}, int'(bus.start_game), (eov != 0) ? 0 : 1);
        step(2);
        chk({tag, " ticks"}, ticks - t0, etk);
    endtask

    // Press start for 4 cycles; the bench counter clears while clear_n is low.
    task automatic press(output int low);
        low = 0;
        bus.start_btn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 3) bus.start_btn = 1'b0;
            if (!bus.timer_clear_n) begin
                low++;
                bus.elapsed_time = 6'd0;
                last_drv = 0;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " start_game"}, int'(bus.start_game), 0);
        chk({tag, " clear_n"}, int'(bus.timer_clear_n), 0);
        chk({tag, " active"}, int'(bus.game_active), 0);
        chk({tag, " over"}, int'(bus.game_over), 0);
        chk({tag, " tick"}, int'(bus.sec_tick), 0);
        chk({tag, " tens"}, int'(bus.time_tens), GS / 10);
        chk({tag, " ones"}, int'(bus.time_ones), GS % 10);
    endtask

    initial begin
        vec_t tbl [10];
        int low, c, r, rem, f0;
        tbl = '{'{1, 3, 5, 9, 0}, '{2, 0, 5, 8, 0}, '{9, 2, 5, 1, 0},
                '{10, 1, 5, 0, 0}, '{23, 3, 3, 7, 0}, '{45, 0, 1, 5, 0},
                '{59, 2, 0, 1, 0}, '{60, 3, 0, 0, 1}, '{63, 1, 0, 0, 1},
                '{0, 2, 0, 0, 1}};
        bus.start_btn = 1'b0;
        bus.pause_sw = 1'b0;
        bus.elapsed_time = 6'd0;
        step(3);
        chk_reset_vals("reset");
        reset = 1'b1;
        step(2);

        press(low);
        chk("t1 start_game", int'(bus.start_game), 1);
        chk("t1 active", int'(bus.game_active), 1);
        chk("t1 clear_n", int'(bus.timer_clear_n), 1);
        chk("t1 tens", int'(bus.time_tens), 6);
        chk("t1 ones", int'(bus.time_ones), 0);

        for (int i = 0; i < 10; i++)
            apply($sformatf("vec%0d", i), tbl[i].sec, tbl[i].ng,
                  tbl[i].tens, tbl[i].ones, tbl[i].over, 1);

        press(low);
        chk("over restart clear len", low, CC);
        chk("over restart over", int'(bus.game_over), 0);
        chk("over restart start", int'(bus.start_game), 1);
        chk("over restart tens", int'(bus.time_tens), 6);

        apply("p23", 23, 2, 3, 7, 0, 1);
        bus.pause_sw = 1'b1;
        step(5);
        chk("pause start_game", int'(bus.start_game), 0);
        chk("pause active", int'(bus.game_active), 0);
        chk("pause clear_n", int'(bus.timer_clear_n), 1);
        chk("pause tens", int'(bus.time_tens), 3);
        chk("pause ones", int'(bus.time_ones), 7);
        bus.pause_sw = 1'b0;
        step(5);
        chk("resume start_game", int'(bus.start_game), 1);
        bus.pause_sw = 1'b1;
        step(5);
        press(low);
        chk("pause restart clear len", low, CC);
        chk("pause restart tens", int'(bus.time_tens), 6);
        chk("pause restart ones", int'(bus.time_ones), 0);
        chk("pause restart held", int'(bus.start_game), 0);
        bus.pause_sw = 1'b0;
        step(5);
        chk("pause restart run", int'(bus.start_game), 1);

        apply("h60", 60, 0, 0, 0, 1, 1);
        f0 = falls;
        bus.start_btn = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!bus.timer_clear_n) begin
                bus.elapsed_time = 6'd0;
                last_drv = 0;
            end
        end
        chk("hold restarts", falls - f0, 1);
        chk("hold start_game", int'(bus.start_game), 1);
        chk("hold tens", int'(bus.time_tens), 6);
        bus.start_btn = 1'b0;
        step(4);
        apply("r5", 5, 1, 5, 5, 0, 1);
        f0 = falls;
        bus.start_btn = 1'b1;
        step(4);
        bus.start_btn = 1'b0;
        step(10);
        chk("run press restarts", falls - f0, 0);
        chk("run press clear_n", int'(bus.timer_clear_n), 1);
        chk("run press tens", int'(bus.time_tens), 5);
        chk("run press ones", int'(bus.time_ones), 5);

        c = 5;
        for (int it = 0; it < 400 && c < GS; it++) begin
            r = int'($urandom_range(0, 7));
            rem = GS - c;
            if (r == 0) begin
                bus.pause_sw = 1'b1;
                step(int'($urandom_range(4, 10)));
                chk("rnd pause start", int'(bus.start_game), 0);
                chk("rnd pause tens", int'(bus.time_tens), rem / 10);
                chk("rnd pause ones", int'(bus.time_ones), rem % 10);
                bus.pause_sw = 1'b0;
                step(5);
                chk("rnd resume start", int'(bus.start_game), 1);
            end else begin
                if (r != 1) c++;
                rem = (c >= GS) ? 0 : GS - c;
                apply($sformatf("rnd%0d", c), c,
                      int'($urandom_range(0, 3)), rem / 10, rem % 10,
                      (c >= GS) ? 1 : 0, (r != 1) ? 1 : 0);
            end
        end
        chk("rnd reached over", int'(bus.game_over), 1);

        press(low);
        chk("rnd restart clear len", low, CC);
        apply("r40", 40, 1, 2, 0, 0, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_vals("midreset");
        bus.elapsed_time = 6'd0;
        last_drv = 0;
        step(3);
        reset = 1'b1;
        step(6);
        chk_reset_vals("after reset idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
